// File: rtl/counter_pkg.sv
// Shared types and constants for the parametrised event/timebase counter.
package counter_pkg;

  typedef enum logic {
    RUN = 1'b0,
    SAT = 1'b1
  } cnt_state_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_PRESC_W = 4;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: emits one tick every (presc+1) enabled cycles.
module counter_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] pc;

  assign tick = en && (pc == presc);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (clr || tick) begin
      pc <= '0;
    end else if (en) begin
      pc <= pc + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/counter_param_ctrl.sv
// Up/down modulo counter with load, wrap-or-saturate bounds, prescaled enable,
// terminal-count pulse and sticky overflow. FSM state is exported on `state`.
//
// Handshake: none; `load` and a prescaler tick are single-cycle strobes sampled
// on the rising edge, with priority rst > load > tick.
module counter_param_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up_dn,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   max_val,
  input  logic [WIDTH-1:0]   match_val,
  input  logic               sat_mode,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr_ovf,
  output logic [WIDTH-1:0]   out,
  output logic               exact,
  output logic               tc,
  output logic               ovf,
  output cnt_state_e         state
);

  logic             tick;
  cnt_state_e       state_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             tc_nxt;
  logic             ovf_set;
  logic             sat_up, sat_up_nxt;
  logic             at_top, at_bottom;

  counter_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clr   (load),
    .presc (presc),
    .tick  (tick)
  );

  assign exact     = (out == match_val);
  assign at_top    = (out >= max_val);
  assign at_bottom = (out == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      out    <= '0;
      tc     <= 1'b0;
      ovf    <= 1'b0;
      sat_up <= 1'b0;
    end else begin
      state  <= state_nxt;
      out    <= out_nxt;
      tc     <= tc_nxt;
      sat_up <= sat_up_nxt;
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    out_nxt    = out;
    tc_nxt     = 1'b0;
    ovf_set    = 1'b0;
    sat_up_nxt = sat_up;

    if (load) begin
      out_nxt   = load_val;
      state_nxt = RUN;
    end else if (tick) begin
      // SAT only holds while sat_mode stays set; otherwise the tick is a RUN tick.
      if (state == SAT && sat_mode) begin
        if (up_dn != sat_up) begin
          out_nxt   = (up_dn == DIR_UP) ? out + WIDTH'(1) : out - WIDTH'(1);
          state_nxt = RUN;
        end
      end else begin
        state_nxt = RUN;
        if (up_dn == DIR_UP) begin
          if (!at_top) begin
            out_nxt = out + WIDTH'(1);
          end else begin
            tc_nxt  = 1'b1;
            ovf_set = 1'b1;
            if (sat_mode) begin
              out_nxt    = max_val;
              state_nxt  = SAT;
              sat_up_nxt = DIR_UP;
            end else begin
              out_nxt = '0;
            end
          end
        end else begin
          if (!at_bottom) begin
            out_nxt = out - WIDTH'(1);
          end else begin
            tc_nxt  = 1'b1;
            ovf_set = 1'b1;
            if (sat_mode) begin
              state_nxt  = SAT;
              sat_up_nxt = DIR_DN;
            end else begin
              out_nxt = max_val;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_param_ctrl.sv
// Bench for counter_param_ctrl: directed scenarios plus random traffic, all
// checked every cycle against an arithmetic reference model.
module tb_counter_param_ctrl;
  import counter_pkg::*;

  localparam int WIDTH   = 8;
  localparam int PRESC_W = 4;
  localparam int MOD     = 1 << WIDTH;
  localparam int PMOD    = 1 << PRESC_W;

  logic               clk;
  logic               rst;
  logic               en;
  logic               up_dn;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]   max_val;
  logic [WIDTH-1:0]   match_val;
  logic               sat_mode;
  logic [PRESC_W-1:0] presc;
  logic               clr_ovf;
  logic [WIDTH-1:0]   out;
  logic               exact;
  logic               tc;
  logic               ovf;
  cnt_state_e         state;

  counter_param_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up_dn     (up_dn),
    .load      (load),
    .load_val  (load_val),
    .max_val   (max_val),
    .match_val (match_val),
    .sat_mode  (sat_mode),
    .presc     (presc),
    .clr_ovf   (clr_ovf),
    .out       (out),
    .exact     (exact),
    .tc        (tc),
    .ovf       (ovf),
    .state     (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int tc_seen = 0;
  int exact_seen = 0;

  // reference model state
  int m_out = 0;
  int m_pc = 0;
  int m_tc = 0;
  int m_ovf = 0;
  int m_sat = 0;
  int m_sat_up = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Applies the counting rules to the inputs seen at this rising edge.
  task automatic model_step();
    int tick_now;
    int wrapped;
    int mx;
    mx = int'(max_val);
    if (rst) begin
      m_out = 0; m_pc = 0; m_tc = 0; m_ovf = 0; m_sat = 0;
    end else begin
      tick_now = (en && m_pc == int'(presc)) ? 1 : 0;
      wrapped = 0;
      if (load) begin
        m_out = int'(load_val);
        m_sat = 0;
        m_pc = 0;
      end else begin
        if (tick_now != 0) m_pc = 0;
        else if (en) m_pc = (m_pc + 1) % PMOD;
        if (tick_now != 0) begin
          if (m_sat != 0 && sat_mode) begin
            if (int'(up_dn) != m_sat_up) begin
              m_out = up_dn ? (m_out + 1) % MOD : (m_out + MOD - 1) % MOD;
              m_sat = 0;
            end
          end else begin
            m_sat = 0;
            if (up_dn && m_out < mx) m_out = m_out + 1;
            else if (!up_dn && m_out > 0) m_out = m_out - 1;
            else begin
              wrapped = 1;
              if (sat_mode) begin
                m_sat = 1;
                m_sat_up = int'(up_dn);
                if (up_dn) m_out = mx;
              end else begin
                m_out = up_dn ? 0 : mx;
              end
            end
          end
        end
      end
      m_tc = wrapped;
      if (wrapped != 0) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
    end
    exp_q.push_back(WIDTH'(m_out));
  endtask

  // driver: one clock, model update, then compare away from the edge
  task automatic step_cycle();
    logic [WIDTH-1:0] e_out;
    @(posedge clk);
    model_step();
    #1;
    e_out = exp_q.pop_front();
    check("out", 32'(out), 32'(e_out));
    check("tc", 32'(tc), 32'(m_tc));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("exact", 32'(exact), 32'(e_out == match_val));
    check("state", 32'(state), 32'(m_sat));
    if (tc) tc_seen++;
    if (exact) exact_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    tc_seen = 0;
    exact_seen = 0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = DIR_UP; load = 1'b0; load_val = '0;
    max_val = 8'd255; match_val = '0; sat_mode = 1'b0; presc = '0; clr_ovf = 1'b0;
    run(2);
    check("reset_out", 32'(out), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);

    // free-run wrap at all-ones
    do_reset();
    en = 1'b1;
    run(260);
    check("free_out", 32'(out), 32'd4);
    check("free_tc_cnt", 32'(tc_seen), 32'd1);
    check("free_ovf", 32'(ovf), 32'd1);

    // modulo 10 with match
    do_reset();
    max_val = 8'd9; match_val = 8'd5;
    run(10);
    check("mod_out", 32'(out), 32'd0);
    check("mod_exact_cnt", 32'(exact_seen), 32'd1);
    check("mod_tc_cnt", 32'(tc_seen), 32'd1);

    // saturate then reverse
    do_reset();
    sat_mode = 1'b1;
    run(15);
    check("sat_hold", 32'(out), 32'd9);
    check("sat_tc_cnt", 32'(tc_seen), 32'd1);
    check("sat_state", 32'(state), 32'(SAT));
    up_dn = DIR_DN;
    run(1);
    check("rev_out", 32'(out), 32'd8);
    check("rev_state", 32'(state), 32'(RUN));
    tc_seen = 0;
    run(12);
    check("dn_hold", 32'(out), 32'd0);
    check("dn_tc_cnt", 32'(tc_seen), 32'd1);

    // prescaler with enable gaps
    sat_mode = 1'b0; up_dn = DIR_UP;
    do_reset();
    max_val = 8'd255; presc = 4'd3;
    run(16);
    check("presc_out", 32'(out), 32'd4);
    run(2);
    en = 1'b0;
    run(5);
    check("en_freeze", 32'(out), 32'd4);
    en = 1'b1;
    run(2);
    check("presc_resume", 32'(out), 32'd5);

    // load priority and out above max
    presc = '0;
    do_reset();
    max_val = 8'd100;
    load = 1'b1; load_val = 8'd200;
    run(1);
    load = 1'b0;
    check("load_out", 32'(out), 32'd200);
    run(1);
    check("over_wrap", 32'(out), 32'd0);
    check("over_tc", 32'(tc), 32'd1);
    load = 1'b1; load_val = 8'd100;
    run(1);
    load = 1'b0; clr_ovf = 1'b1;
    run(1);
    check("set_beats_clr", 32'(ovf), 32'd1);
    run(1);
    clr_ovf = 1'b0;
    check("clr_ovf", 32'(ovf), 32'd0);

    // sync reset mid-count, and a pulse between edges
    max_val = 8'd36; load = 1'b1; load_val = 8'd36;
    run(1);
    load = 1'b0;
    run(1);
    max_val = 8'd255; load = 1'b1;
    run(1);
    load = 1'b0;
    run(1);
    check("pre_rst_out", 32'(out), 32'd37);
    rst = 1'b1; #2; rst = 1'b0;
    run(1);
    check("glitch_rst", 32'(out), 32'd38);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check("rst_out", 32'(out), 32'd0);
    check("rst_tc", 32'(tc), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) begin
        max_val   = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 20));
        match_val = 8'($urandom_range(0, 20));
        presc     = 4'($urandom_range(0, 2));
      end
      if (i % 25 == 0) sat_mode = 1'($urandom_range(0, 1));
      if (i % 12 == 0) up_dn = 1'($urandom_range(0, 1));
      rst      = ($urandom_range(0, 99) < 2);
      load     = ($urandom_range(0, 15) == 0);
      load_val = 8'($urandom_range(0, 255));
      en       = ($urandom_range(0, 3) != 0);
      clr_ovf  = ($urandom_range(0, 7) == 0);
      run(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
